tp84_snd_irq_gen: RTL and testbench



---
 rtl/tp84_snd_pkg.sv | 36 +++
 rtl/tp84_sync_edge.sv | 55 +++++
 rtl/tp84_snd_irq_gen.sv | 163 ++++++++++++++++
 tb/tb_tp84_snd_irq_gen.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tp84_snd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tp84_snd_pkg
//  Purpose  : Shared types and default constants for the sound-board
//             interrupt generator and its input conditioning.
//  Contents : irq_state_t   - interrupt request FSM state (2-bit)
//             TP84_SYNC_STAGES_DEF, TP84_IRQ_FILTER_DEF - default depths
//             tp84_cnt_w()  - counter width helper
//  Revision : 1.0 - initial release
// ============================================================================
package tp84_snd_pkg;

    // Request lifecycle: nothing seen, qualifying a rising edge, waiting for
    // the Z80 clock enable, and INT_n driven low until acknowledged.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        QUAL   = 2'd1,
        PEND   = 2'd2,
        ASSERT = 2'd3
    } irq_state_t;

    localparam int TP84_SYNC_STAGES_DEF = 2;
    localparam int TP84_IRQ_FILTER_DEF  = 4;

    // Width needed to hold the values 0..max_val inclusive.
    function automatic int tp84_cnt_w(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : tp84_snd_pkg
`default_nettype wire

// File: rtl/tp84_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : tp84_sync_edge
//  Purpose  : Multi-flop synchroniser for an asynchronous level input plus a
//             rising-edge detector on the synchronised level. Intended for
//             reuse on the IRQ trigger, coin and service inputs.
//  Ports    : clk_49m  - system clock
//             n_rst    - asynchronous active-low reset
//             i_din    - raw asynchronous input
//             o_sync   - synchronised level (i_din delayed STAGES edges)
//             o_rise   - one-cycle pulse on a low->high of o_sync
//  Revision : 1.0 - initial release
// ============================================================================
module tp84_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_49m,
    input  logic n_rst,
    input  logic i_din,
    output logic o_sync,
    output logic o_rise
);

    logic [STAGES-1:0] r_sync;
    logic [STAGES-1:0] r_fill;
    logic              r_prev;
    logic              w_fill_done;
    logic              w_sync;

    // The chain resets to zero, so its output is not a real sample of i_din
    // until STAGES edges after reset. r_fill tracks that; the previous sample
    // (reset to 1) is only updated from real samples. Without this, an input
    // already high when reset releases would appear as a fresh 0->1 edge.
    assign w_fill_done = r_fill[STAGES-1];
    assign w_sync      = r_sync[STAGES-1];

    always_ff @(posedge clk_49m or negedge n_rst) begin
        if (!n_rst) begin
            r_sync <= '0;
            r_fill <= '0;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_din};
            r_fill <= {r_fill[STAGES-2:0], 1'b1};
            if (w_fill_done) begin
                r_prev <= w_sync;
            end
        end
    end

    assign o_sync = w_sync;
    assign o_rise = w_fill_done & w_sync & ~r_prev;

endmodule : tp84_sync_edge
`default_nettype wire

// File: rtl/tp84_snd_irq_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tp84_snd_irq_gen
//  Purpose  : Clocked replacement for the sound board's edge-triggered Z80
//             interrupt flop. Synchronises and glitch-filters the CPU-board
//             trigger, drives INT_n low aligned to the Z80 clock enable and
//             holds it until the acknowledge-derived clear.
//  Ports    : clk_49m     - 49.152 MHz system clock
//             n_irq_clr   - async active-low clear (reset or IORQ&M1 ack)
//             cen_3m58    - Z80 clock enable, one clk_49m cycle wide
//             irq_trigger - raw request from CPU board (asynchronous)
//             n_irq       - Z80 INT_n, active-low, registered
//             irq_pending - request accepted, INT_n not yet driven
//             irq_age     - cen_3m58 ticks since n_irq fell, saturating
//             retrig      - sticky: qualified edge seen while asserted
//  Revision : 1.0 - initial release
// ============================================================================
module tp84_snd_irq_gen
    import tp84_snd_pkg::*;
#(
    parameter int SYNC_STAGES   = TP84_SYNC_STAGES_DEF,
    parameter int FILTER_CYCLES = TP84_IRQ_FILTER_DEF,
    parameter int AGE_W         = 8
) (
    input  logic             clk_49m,
    input  logic             n_irq_clr,
    input  logic             cen_3m58,
    input  logic             irq_trigger,
    output logic             n_irq,
    output logic             irq_pending,
    output logic [AGE_W-1:0] irq_age,
    output logic             retrig
);

    localparam int                 c_CNT_W     = tp84_cnt_w(FILTER_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(FILTER_CYCLES - 1);
    localparam logic [AGE_W-1:0]   c_AGE_MAX   = {AGE_W{1'b1}};
    localparam bit                 c_FILT_ONE  = (FILTER_CYCLES == 1);

    irq_state_t         r_state;
    irq_state_t         w_state_nxt;
    logic [c_CNT_W-1:0] r_filt_cnt;
    logic               r_n_irq;
    logic [AGE_W-1:0]   r_age;
    logic               r_retrig;

    logic               w_s;
    logic               w_rise;
    logic               w_qual;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    tp84_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk_49m (clk_49m),
        .n_rst   (n_irq_clr),
        .i_din   (irq_trigger),
        .o_sync  (w_s),
        .o_rise  (w_rise)
    );

    // ------------------------------------------------------------------
    // Glitch filter
    // Counts consecutive high synced samples starting at a rising edge; the
    // edge cycle itself is sample 1. w_qual pulses on the cycle in which the
    // FILTER_CYCLES-th consecutive high sample is present. The counter runs
    // independently of the FSM so that an edge which begins in PEND and
    // completes in ASSERT still counts as a re-trigger.
    // ------------------------------------------------------------------
    assign w_qual = (w_rise & c_FILT_ONE)
                  | ((r_filt_cnt != '0) & w_s & (r_filt_cnt == c_CNT_LAST));

    always_ff @(posedge clk_49m or negedge n_irq_clr) begin
        if (!n_irq_clr) begin
            r_filt_cnt <= '0;
        end else if (w_rise) begin
            r_filt_cnt <= c_FILT_ONE ? '0 : c_CNT_ONE;
        end else if (r_filt_cnt != '0) begin
            if (!w_s || w_qual) begin
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + c_CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_49m or negedge n_irq_clr) begin
        if (!n_irq_clr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_qual) begin
                    w_state_nxt = PEND;
                end else if (w_rise) begin
                    w_state_nxt = QUAL;
                end
            end
            QUAL: begin
                // A drop before the filter completes is a glitch.
                if (!w_s) begin
                    w_state_nxt = IDLE;
                end else if (w_qual) begin
                    w_state_nxt = PEND;
                end
            end
            PEND: begin
                if (cen_3m58) begin
                    w_state_nxt = ASSERT;
                end
            end
            ASSERT: begin
                // Only the asynchronous clear leaves this state.
                w_state_nxt = ASSERT;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_49m or negedge n_irq_clr) begin
        if (!n_irq_clr) begin
            r_n_irq  <= 1'b1;
            r_age    <= '0;
            r_retrig <= 1'b0;
        end else begin
            // Decode from next state so INT_n falls on the same edge that
            // enters ASSERT, i.e. on the cen_3m58 cycle.
            r_n_irq <= (w_state_nxt != ASSERT);

            if ((r_state == ASSERT) && cen_3m58 && (r_age != c_AGE_MAX)) begin
                r_age <= r_age + AGE_W'(1);
            end

            if ((r_state == ASSERT) && w_qual) begin
                r_retrig <= 1'b1;
            end
        end
    end

    assign n_irq       = r_n_irq;
    assign irq_age     = r_age;
    assign retrig      = r_retrig;
    assign irq_pending = (r_state == QUAL) || (r_state == PEND);

endmodule : tp84_snd_irq_gen
`default_nettype wire

// File: tb/tb_tp84_snd_irq_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tp84_snd_irq_gen
//  Purpose  : Self-checking bench for tp84_snd_irq_gen with a behavioural
//             reference model and directed scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tp84_snd_irq_gen;

    localparam int SYNC    = 2;
    localparam int FILT    = 4;
    localparam int AGE_W   = 8;
    localparam int AGE_MAX = (1 << AGE_W) - 1;

    logic             clk_49m     = 1'b0;
    logic             n_irq_clr   = 1'b0;
    logic             cen_3m58    = 1'b0;
    logic             irq_trigger = 1'b0;
    logic             n_irq;
    logic             irq_pending;
    logic [AGE_W-1:0] irq_age;
    logic             retrig;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_on   = 1'b0;
    bit cen_per  = 1'b0;
    int ph       = 0;

    tp84_snd_irq_gen #(
        .SYNC_STAGES   (SYNC),
        .FILTER_CYCLES (FILT),
        .AGE_W         (AGE_W)
    ) dut (
        .clk_49m     (clk_49m),
        .n_irq_clr   (n_irq_clr),
        .cen_3m58    (cen_3m58),
        .irq_trigger (irq_trigger),
        .n_irq       (n_irq),
        .irq_pending (irq_pending),
        .irq_age     (irq_age),
        .retrig      (retrig)
    );

    always #5 clk_49m = ~clk_49m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model, written from the behavioural rules:
    //   s         = trigger sampled SYNC edges ago, meaningful only once SYNC
    //               edges have passed since the clear released
    //   run       = number of consecutive high samples since a 0->1 of s
    //   qualified = run reaches FILT exactly on this edge
    //   a qualified request waits for cen, then INT_n stays low until clear
    // ------------------------------------------------------------------
    int           m_since  = 0;
    logic [SYNC-1:0] m_hist = '0;
    logic         m_prev   = 1'b1;
    int           m_run    = 0;
    logic         m_req    = 1'b0;
    logic         m_asrt   = 1'b0;
    logic         m_retrig = 1'b0;
    int           m_age    = 0;

    always @(posedge clk_49m or negedge n_irq_clr) begin : p_model
        logic s_ok;
        logic s;
        logic rise;
        logic qual;
        if (!n_irq_clr) begin
            m_since  = 0;
            m_hist   = '0;
            m_prev   = 1'b1;
            m_run    = 0;
            m_req    = 1'b0;
            m_asrt   = 1'b0;
            m_retrig = 1'b0;
            m_age    = 0;
        end else begin
            s_ok = (m_since >= SYNC);
            s    = m_hist[SYNC-1];
            rise = s_ok && s && !m_prev;

            if (!s_ok || !s)                        m_run = 0;
            else if (rise)                          m_run = 1;
            else if (m_run != 0 && m_run <= FILT)   m_run = m_run + 1;
            qual = (m_run == FILT);

            if (s_ok) m_prev = s;

            if (m_asrt && cen_3m58 && m_age < AGE_MAX) m_age = m_age + 1;
            if (m_asrt && qual) m_retrig = 1'b1;

            if (m_req && cen_3m58) begin
                m_asrt = 1'b1;
                m_req  = 1'b0;
            end else if (!m_asrt && qual) begin
                m_req = 1'b1;
            end

            m_hist = {m_hist[SYNC-2:0], irq_trigger};
            if (m_since < 1000) m_since = m_since + 1;
        end
    end

    always @(negedge clk_49m) begin
        if (cmp_on) begin
            chk("model_n_irq",   n_irq,   !m_asrt);
            chk("model_pending", irq_pending,
                !m_asrt && (m_req || (m_run >= 1 && m_run < FILT)));
            chk("model_age",     irq_age, m_age);
            chk("model_retrig",  retrig,  m_retrig);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus. After tick() the time is 2 ns past the edge just taken.
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk_49m);
        #2;
        if (cen_per) begin
            ph       = (ph == 13) ? 0 : ph + 1;
            cen_3m58 = (ph == 0);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk_49m);
        #2;
        chk("rst_n_irq",   n_irq,       1);
        chk("rst_pending", irq_pending, 0);
        chk("rst_age",     irq_age,     0);
        chk("rst_retrig",  retrig,      0);
        n_irq_clr = 1'b1;
        cmp_on    = 1'b1;
        cen_3m58  = 1'b1;
        ticks(5);

        // Short pulse: 3 synced cycles high, rejected
        irq_trigger = 1'b1;
        ticks(3);
        chk("pulse_pend_e3", irq_pending, 1);
        irq_trigger = 1'b0;
        ticks(2);
        chk("pulse_pend_e5", irq_pending, 1);
        tick();
        chk("pulse_pend_e6", irq_pending, 0);
        ticks(10);
        chk("pulse_n_irq", n_irq, 1);

        // Basic latency with cen tied high
        irq_trigger = 1'b1;
        ticks(2);
        chk("lat_pend_e2", irq_pending, 0);
        tick();
        chk("lat_pend_e3", irq_pending, 1);
        ticks(3);
        chk("lat_pend_e6",  irq_pending, 1);
        chk("lat_n_irq_e6", n_irq,       1);
        tick();
        chk("lat_n_irq_e7", n_irq,       0);
        chk("lat_pend_e7",  irq_pending, 0);
        chk("lat_age_e7",   irq_age,     0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("lat_age_count", irq_age, i);
        end

        // Clear while asserted, trigger still high
        n_irq_clr = 1'b0;
        #1;
        chk("clr_n_irq", n_irq,   1);
        chk("clr_age",   irq_age, 0);
        tick();
        n_irq_clr = 1'b1;
        ticks(20);
        chk("clr_no_refire", n_irq, 1);
        irq_trigger = 1'b0;
        ticks(3);
        irq_trigger = 1'b1;
        ticks(6);
        chk("refire_e6", n_irq, 1);
        tick();
        chk("refire_e7", n_irq, 0);

        // Retrigger while asserted
        irq_trigger = 1'b0;
        ticks(3);
        irq_trigger = 1'b1;
        ticks(6);
        irq_trigger = 1'b0;
        chk("retrig_set",   retrig, 1);
        chk("retrig_n_irq", n_irq,  0);
        ticks(3);
        chk("retrig_hold",  retrig, 1);
        n_irq_clr = 1'b0;
        #1;
        chk("retrig_clr",       retrig, 0);
        chk("retrig_clr_n_irq", n_irq,  1);
        tick();
        n_irq_clr = 1'b1;

        // Clear two cycles into QUAL
        ticks(5);
        irq_trigger = 1'b1;
        ticks(5);
        chk("abort_pend_before", irq_pending, 1);
        n_irq_clr = 1'b0;
        #1;
        chk("abort_pend_async", irq_pending, 0);
        tick();
        n_irq_clr = 1'b1;
        ticks(20);
        chk("abort_n_irq",  n_irq,       1);
        chk("abort_pend",   irq_pending, 0);

        // cen every 14 cycles; qualification 5 cycles before a cen
        irq_trigger = 1'b0;
        ticks(4);
        ph       = 0;
        cen_3m58 = 1'b0;
        cen_per  = 1'b1;
        for (int i = 0; i < 20 && !cen_3m58; i++) tick();
        chk("cen_found", cen_3m58, 1);
        ticks(4);
        irq_trigger = 1'b1;
        ticks(10);
        chk("cen_wait_n_irq", n_irq,       1);
        chk("cen_wait_pend",  irq_pending, 1);
        tick();
        chk("cen_fall_n_irq", n_irq,       0);
        ticks(300 * 14);
        chk("age_sat",      irq_age, AGE_MAX);
        ticks(28);
        chk("age_sat_hold", irq_age, AGE_MAX);
        chk("age_n_irq",    n_irq,   0);

        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_tp84_snd_irq_gen
`default_nettype wire
